// File: rtl/dmem_pkg.sv
// Shared types for the data-memory port arbiter: requester identity, request bundle
// and the response-tracker tag.
package dmem_pkg;

    localparam int RD_LAT_MAX  = 3;
    localparam int DMEM_ADDR_W = 10;
    localparam int WORD_W      = 32;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_HOST = 1'b1
    } owner_e;

    // The address field carries the package width; the top casts to/from its ADDR_W.
    typedef struct packed {
        logic [3:0]             we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [WORD_W-1:0]      wdata;
    } mem_req_t;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } rsp_tag_t;

endpackage

// File: rtl/dmem_rsp_tracker.sv
// Delay line of {valid, owner} tags matching the BRAM read latency; the head tag says
// which requester owns the read data arriving this cycle.
module dmem_rsp_tracker
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   push_valid,
    input  owner_e push_owner,
    output logic   head_valid,
    output owner_e head_owner
);

    rsp_tag_t stage_reg  [DEPTH];
    rsp_tag_t stage_next [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head_in
                assign stage_next[gi] = '{valid: push_valid, owner: push_owner};
            end else begin : g_shift
                assign stage_next[gi] = stage_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_reg[i] <= '{valid: 1'b0, owner: OWN_CORE};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_reg[i] <= stage_next[i];
            end
        end
    end

    assign head_valid = stage_reg[DEPTH-1].valid;
    assign head_owner = stage_reg[DEPTH-1].owner;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data BRAM port between the core load/store path and the host
// loader, and steers read data back to whichever requester issued the read.
module dmem_port_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W       = DMEM_ADDR_W,
    parameter int RD_LATENCY   = 1,
    parameter int HOST_MAX_RUN = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_c_req,
    input  logic [3:0]        i_c_we,
    input  logic [ADDR_W-1:0] i_c_addr,
    input  logic [31:0]       i_c_wdata,
    output logic              o_c_gnt,
    output logic              o_c_rvalid,
    output logic [31:0]       o_c_rdata,
    input  logic              i_h_req,
    input  logic [3:0]        i_h_we,
    input  logic [ADDR_W-1:0] i_h_addr,
    input  logic [31:0]       i_h_wdata,
    output logic              o_h_gnt,
    output logic              o_h_rvalid,
    output logic [31:0]       o_h_rdata,
    output logic              o_mem_en,
    output logic [3:0]        o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata
);

    localparam logic [3:0] RUN_LIMIT = 4'(HOST_MAX_RUN);

    owner_e     last_gnt_reg;
    logic [3:0] host_run_reg;
    mem_req_t   last_req_reg;

    mem_req_t c_req_s;
    mem_req_t h_req_s;
    mem_req_t sel_req;
    logic     c_gnt;
    logic     h_gnt;
    logic     host_wins_conflict;
    logic     rsp_valid;
    owner_e   rsp_owner;

    assign c_req_s = '{we: i_c_we, addr: DMEM_ADDR_W'(i_c_addr), wdata: i_c_wdata};
    assign h_req_s = '{we: i_h_we, addr: DMEM_ADDR_W'(i_h_addr), wdata: i_h_wdata};

    // Host keeps a conflict while it is mid-run (or core had the last turn), until the cap.
    assign host_wins_conflict = (host_run_reg != RUN_LIMIT) &&
                                ((last_gnt_reg == OWN_CORE) || (host_run_reg != 4'd0));

    always_comb begin
        c_gnt = 1'b0;
        h_gnt = 1'b0;
        if (reset_n) begin
            if (i_c_req && i_h_req) begin
                if (host_wins_conflict) begin
                    h_gnt = 1'b1;
                end else begin
                    c_gnt = 1'b1;
                end
            end else begin
                c_gnt = i_c_req;
                h_gnt = i_h_req;
            end
        end
    end

    always_comb begin
        sel_req    = last_req_reg;
        sel_req.we = 4'b0000;
        if (c_gnt) begin
            sel_req = c_req_s;
        end else if (h_gnt) begin
            sel_req = h_req_s;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_gnt_reg <= OWN_HOST;
            host_run_reg <= 4'd0;
            last_req_reg <= '0;
        end else begin
            if (c_gnt) begin
                last_gnt_reg <= OWN_CORE;
            end else if (h_gnt) begin
                last_gnt_reg <= OWN_HOST;
            end

            if (c_gnt || !i_c_req) begin
                host_run_reg <= 4'd0;
            end else if (h_gnt) begin
                host_run_reg <= host_run_reg + 4'd1;
            end

            if (c_gnt || h_gnt) begin
                last_req_reg <= sel_req;
            end
        end
    end

    dmem_rsp_tracker #(
        .DEPTH (RD_LATENCY)
    ) u_rsp_tracker (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_valid ((c_gnt || h_gnt) && (sel_req.we == 4'b0000)),
        .push_owner (h_gnt ? OWN_HOST : OWN_CORE),
        .head_valid (rsp_valid),
        .head_owner (rsp_owner)
    );

    assign o_c_gnt     = c_gnt;
    assign o_h_gnt     = h_gnt;
    assign o_mem_en    = c_gnt || h_gnt;
    assign o_mem_we    = sel_req.we;
    assign o_mem_addr  = ADDR_W'(sel_req.addr);
    assign o_mem_wdata = sel_req.wdata;

    assign o_c_rvalid = rsp_valid && (rsp_owner == OWN_CORE);
    assign o_h_rvalid = rsp_valid && (rsp_owner == OWN_HOST);
    assign o_c_rdata  = o_c_rvalid ? i_mem_rdata : 32'h0;
    assign o_h_rdata  = o_h_rvalid ? i_mem_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a two-cycle BRAM model and a four-grant host run cap.
module tb_dmem_port_arbiter;

    localparam int ADDR_W = 10;
    localparam int LAT    = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              i_c_req, i_h_req;
    logic [3:0]        i_c_we, i_h_we;
    logic [ADDR_W-1:0] i_c_addr, i_h_addr;
    logic [31:0]       i_c_wdata, i_h_wdata;
    logic              o_c_gnt, o_c_rvalid, o_h_gnt, o_h_rvalid;
    logic [31:0]       o_c_rdata, o_h_rdata;
    logic              o_mem_en;
    logic [3:0]        o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic [31:0]       i_mem_rdata;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    logic [31:0] mem_model [0:1023];
    logic [31:0] rd_pipe [LAT];

    always #5 clk = ~clk;

    dmem_port_arbiter #(
        .ADDR_W       (ADDR_W),
        .RD_LATENCY   (LAT),
        .HOST_MAX_RUN (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_c_req     (i_c_req),
        .i_c_we      (i_c_we),
        .i_c_addr    (i_c_addr),
        .i_c_wdata   (i_c_wdata),
        .o_c_gnt     (o_c_gnt),
        .o_c_rvalid  (o_c_rvalid),
        .o_c_rdata   (o_c_rdata),
        .i_h_req     (i_h_req),
        .i_h_we      (i_h_we),
        .i_h_addr    (i_h_addr),
        .i_h_wdata   (i_h_wdata),
        .o_h_gnt     (o_h_gnt),
        .o_h_rvalid  (o_h_rvalid),
        .o_h_rdata   (o_h_rdata),
        .o_mem_en    (o_mem_en),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata)
    );

    // BRAM model: byte-enabled writes, reads return LAT cycles after the enable.
    always @(posedge clk) begin
        if (o_mem_en) begin
            if (o_mem_we == 4'b0000) begin
                rd_pipe[0] <= mem_model[o_mem_addr];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (o_mem_we[b]) mem_model[o_mem_addr][8*b +: 8] <= o_mem_wdata[8*b +: 8];
                end
            end
        end
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign i_mem_rdata = rd_pipe[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_reqs();
        i_c_req = 1'b0; i_c_we = 4'b0000; i_c_addr = '0; i_c_wdata = '0;
        i_h_req = 1'b0; i_h_we = 4'b0000; i_h_addr = '0; i_h_wdata = '0;
    endtask

    logic        exp_core_seq [7];
    logic [31:0] alt_data [4];

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_core_seq = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        alt_data     = '{32'h1111_0040, 32'h2222_0041, 32'h3333_0042, 32'h4444_0043};
        mem_model[10'h010] = 32'hCAFE_F00D;
        for (int i = 0; i < 4; i++) mem_model[10'h040 + i] = alt_data[i];

        // Reset with both requests raised: no grant may leak out.
        idle_reqs();
        reset_n = 1'b0;
        i_c_req = 1'b1;
        i_h_req = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_c_gnt", 32'(o_c_gnt), 32'd0);
        chk("rst_h_gnt", 32'(o_h_gnt), 32'd0);
        chk("rst_mem_en", 32'(o_mem_en), 32'd0);
        chk("rst_mem_we", 32'(o_mem_we), 32'd0);
        chk("rst_mem_addr", 32'(o_mem_addr), 32'd0);
        chk("rst_mem_wdata", o_mem_wdata, 32'd0);
        chk("rst_c_rvalid", 32'(o_c_rvalid), 32'd0);
        chk("rst_h_rvalid", 32'(o_h_rvalid), 32'd0);

        next_cycle();
        reset_n = 1'b1;
        idle_reqs();

        // Core read of 0x10 alone.
        next_cycle();
        i_c_req = 1'b1; i_c_we = 4'b0000; i_c_addr = 10'h010;
        @(negedge clk);
        $display("core read addr=%h", i_c_addr);
        chk("rd_c_gnt", 32'(o_c_gnt), 32'd1);
        chk("rd_h_gnt", 32'(o_h_gnt), 32'd0);
        chk("rd_mem_en", 32'(o_mem_en), 32'd1);
        chk("rd_mem_addr", 32'(o_mem_addr), 32'h010);
        chk("rd_mem_we", 32'(o_mem_we), 32'd0);
        next_cycle();
        idle_reqs();
        @(negedge clk);
        chk("rd_lat1_c_rvalid", 32'(o_c_rvalid), 32'd0);
        chk("rd_idle_mem_en", 32'(o_mem_en), 32'd0);
        chk("rd_idle_addr_hold", 32'(o_mem_addr), 32'h010);
        next_cycle();
        @(negedge clk);
        chk("rd_lat2_c_rvalid", 32'(o_c_rvalid), 32'd1);
        chk("rd_lat2_c_rdata", o_c_rdata, 32'hCAFE_F00D);
        chk("rd_lat2_h_rvalid", 32'(o_h_rvalid), 32'd0);
        chk("rd_lat2_h_rdata", o_h_rdata, 32'd0);
        $display("core read response data=%h", o_c_rdata);
        next_cycle();
        @(negedge clk);
        chk("rd_after_c_rvalid", 32'(o_c_rvalid), 32'd0);

        // Reset one cycle after a core read grant drops the in-flight response.
        next_cycle();
        i_c_req = 1'b1; i_c_we = 4'b0000; i_c_addr = 10'h010;
        @(negedge clk);
        chk("rr_c_gnt", 32'(o_c_gnt), 32'd1);
        next_cycle();
        idle_reqs();
        i_h_req = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("rr_h_gnt", 32'(o_h_gnt), 32'd0);
        chk("rr_mem_en", 32'(o_mem_en), 32'd0);
        chk("rr_mem_addr", 32'(o_mem_addr), 32'd0);
        chk("rr_c_rvalid", 32'(o_c_rvalid), 32'd0);
        next_cycle();
        reset_n = 1'b1;
        idle_reqs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rr_stale_c_rvalid", 32'(o_c_rvalid), 32'd0);
            next_cycle();
        end

        // Both requesting from the first conflict after reset: C,H,H,H,H,C,H.
        i_c_req = 1'b1; i_c_we = 4'b1111; i_c_addr = 10'h020; i_c_wdata = 32'h1111_1111;
        i_h_req = 1'b1; i_h_we = 4'b1111; i_h_addr = 10'h021; i_h_wdata = 32'h2222_2222;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            $display("conflict cycle %0d core_gnt=%0b host_gnt=%0b", i, o_c_gnt, o_h_gnt);
            chk("rr_seq_c_gnt", 32'(o_c_gnt), 32'(exp_core_seq[i]));
            chk("rr_seq_h_gnt", 32'(o_h_gnt), 32'(!exp_core_seq[i]));
            chk("rr_seq_addr", 32'(o_mem_addr), exp_core_seq[i] ? 32'h020 : 32'h021);
            next_cycle();
        end

        // Core drops its request mid host run; the run count restarts.
        i_c_req = 1'b0;
        @(negedge clk);
        chk("runclr_h_gnt", 32'(o_h_gnt), 32'd1);
        next_cycle();
        i_c_req = 1'b1;
        @(negedge clk);
        chk("runclr_c_gnt", 32'(o_c_gnt), 32'd1);
        chk("runclr_h_gnt0", 32'(o_h_gnt), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("runclr_next_h_gnt", 32'(o_h_gnt), 32'd1);
        next_cycle();

        // Host store-byte write.
        idle_reqs();
        i_h_req = 1'b1; i_h_we = 4'b0100; i_h_addr = 10'h003; i_h_wdata = 32'h00AB_0000;
        @(negedge clk);
        $display("host write addr=%h we=%b data=%h", i_h_addr, i_h_we, i_h_wdata);
        chk("sb_h_gnt", 32'(o_h_gnt), 32'd1);
        chk("sb_mem_we", 32'(o_mem_we), 32'h4);
        chk("sb_mem_addr", 32'(o_mem_addr), 32'h003);
        chk("sb_mem_wdata", o_mem_wdata, 32'h00AB_0000);
        next_cycle();
        idle_reqs();
        @(negedge clk);
        chk("sb_idle_mem_we", 32'(o_mem_we), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("sb_no_h_rvalid", 32'(o_h_rvalid), 32'd0);
            chk("sb_no_c_rvalid", 32'(o_c_rvalid), 32'd0);
            next_cycle();
        end

        // Alternating core/host reads every cycle.
        for (int i = 0; i < 7; i++) begin
            idle_reqs();
            if (i < 4) begin
                if (i % 2 == 0) begin
                    i_c_req = 1'b1; i_c_addr = 10'(10'h040 + i);
                end else begin
                    i_h_req = 1'b1; i_h_addr = 10'(10'h040 + i);
                end
            end
            @(negedge clk);
            if (i < 4) begin
                chk("alt_gnt", {30'd0, o_h_gnt, o_c_gnt}, (i % 2 == 0) ? 32'd1 : 32'd2);
            end
            if (i >= 2 && i < 6) begin
                $display("alt response %0d c_rvalid=%0b h_rvalid=%0b c_rdata=%h h_rdata=%h",
                         i - 2, o_c_rvalid, o_h_rvalid, o_c_rdata, o_h_rdata);
                if ((i - 2) % 2 == 0) begin
                    chk("alt_c_rvalid", 32'(o_c_rvalid), 32'd1);
                    chk("alt_c_rdata", o_c_rdata, alt_data[i-2]);
                    chk("alt_h_rvalid0", 32'(o_h_rvalid), 32'd0);
                    chk("alt_h_rdata0", o_h_rdata, 32'd0);
                end else begin
                    chk("alt_h_rvalid", 32'(o_h_rvalid), 32'd1);
                    chk("alt_h_rdata", o_h_rdata, alt_data[i-2]);
                    chk("alt_c_rvalid0", 32'(o_c_rvalid), 32'd0);
                    chk("alt_c_rdata0", o_c_rdata, 32'd0);
                end
            end
            if (i == 6) begin
                chk("alt_end_c_rvalid", 32'(o_c_rvalid), 32'd0);
                chk("alt_end_h_rvalid", 32'(o_h_rvalid), 32'd0);
            end
            next_cycle();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
